cdiv_seq: RTL and testbench
===========================

Name: cdiv_seq

Overview:
- Sequential complex divider C = A / B for the FFT datapath; the inverse of the complex multiplier. Used for equalisation and normalisation after the transform.
- Operands and result are signed Q1.15.
- Computes C = A·conj(B) / |B|², using a bit-serial restoring division shared by the real and imaginary parts.
- start/busy/done handshake; one division in flight at a time.

Parameters:
- N, 16, operand/result width (Q1.(N-1)); all widths below are given for N=16.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- Ar  in  N  dividend real, signed
- Ai  in  N  dividend imag, signed
- Br  in  N  divisor real, signed
- Bi  in  N  divisor imag, signed
- busy  out  1  division in progress
- done  out  1  one-cycle pulse; Cr/Ci/ovf/dz valid
- Cr  out  N  quotient real, signed Q1.15
- Ci  out  N  quotient imag, signed Q1.15
- ovf  out  1  either part saturated (valid with done)
- dz  out  1  divisor was zero (valid with done)

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, Cr=0, Ci=0, ovf=0, dz=0. Reset mid-division aborts it; no done is produced.
- States: IDLE -> MULT -> DIV -> IDLE.
- IDLE: on start=1 at edge t, register Ar/Ai/Br/Bi, go to MULT, busy=1.
  - start while busy is ignored.
  - start in the cycle done=1 is accepted (FSM is already IDLE).
- MULT (edge t+1): register:
  - Nr = Ar·Br + Ai·Bi (33b signed)
  - Ni = Ai·Br − Ar·Bi (33b signed)
  - D = Br² + Bi² (32b unsigned, max 2^31)
  - signs and magnitudes of Nr/Ni
  - per-part overflow flag = |N| ≥ 2·D
  - dz = (D==0)
  - then go to DIV with bit counter = 16.
- DIV (edges t+2 .. t+18): one restoring step per edge, producing quotient bits 16..0 of Q = floor(|N|·2^15 / D) for both parts in parallel.
  - Remainder width is 34b minimum.
  - The last step updates the outputs and returns to IDLE.
- Result at edge t+18:
  - Apply the sign to Q. Truncation is toward zero.
  - Saturation, per part: pre-flag set, or positive with Q>32767, or negative with Q>32768. Saturated values are 32767 / −32768 by sign.
  - ovf = OR of the per-part saturations.
  - dz=1 forces Cr=Ci=0 and ovf=0.
  - Zero numerator gives 0 regardless of sign.
  - done=1 for exactly the cycle after edge t+18; busy falls on the same edge.
- Latency: done is high 18 edges after the start-accepting edge. Cr/Ci/ovf/dz hold until the next completion or reset.
- Inputs are sampled only at the accept edge; later changes on Ar..Bi have no effect.

Optional Feature:
- Macro: CDIV_ROUND_EN.
- Defined:
  - One extra DIV step computes quotient bit −1, and Q is rounded half away from zero (Q += bit−1) before saturation.
  - Latency becomes 19 edges.
  - Rounding that pushes Q past a limit saturates and sets ovf.
- Undefined: truncation toward zero; 18-edge latency.

Test Plan:
- Real division: A=(8192,0), B=(16384,0), start 1 cycle -> done 18 edges later, Cr=16384, Ci=0, ovf=0, dz=0; busy high for exactly 18 cycles.
- Imaginary divisor and negative result: A=(16384,0), B=(0,−32768) -> Cr=0, Ci=16384. Then A=(−8192,0), B=(16384,0) -> Cr=−16384, Ci=0.
- Saturation and divide-by-zero:
  - A=(16384,0), B=(8192,0) -> Cr=32767, Ci=0, ovf=1.
  - A=(−16384,0), B=(8192,0) -> Cr=−32768, ovf=1.
  - A=(100,−5), B=(0,0) -> Cr=Ci=0, dz=1, ovf=0.
- Truncation versus rounding: A=(1,0), B=(3,0).
  - Without CDIV_ROUND_EN -> Cr=10922, latency 18.
  - With CDIV_ROUND_EN -> Cr=10923, latency 19.
- Handshake:
  - Start asserted while busy is ignored: exactly one done, with the first operands' result.
  - Start in the done cycle is accepted: a second done follows 18 edges later.
  - Inputs changed mid-operation do not alter the result.
- Reset mid-operation: assert reset=0 at edge t+9 -> busy=done=0 and Cr=Ci=0 immediately (async). No done is produced. A fresh start after release completes normally.

Source files
------------

// File: rtl/cdiv_seq_if.sv
// Start/busy/done handshake plus operand and result bundle for the sequential complex divider.
interface cdiv_seq_if #(
  parameter int N = 16
);
  logic                start;
  logic signed [N-1:0] Ar;
  logic signed [N-1:0] Ai;
  logic signed [N-1:0] Br;
  logic signed [N-1:0] Bi;
  logic                busy;
  logic                done;
  logic signed [N-1:0] Cr;
  logic signed [N-1:0] Ci;
  logic                ovf;
  logic                dz;

  modport master (
    output start, Ar, Ai, Br, Bi,
    input  busy, done, Cr, Ci, ovf, dz
  );

  modport slave (
    input  start, Ar, Ai, Br, Bi,
    output busy, done, Cr, Ci, ovf, dz
  );
endinterface

// File: rtl/cdiv_seq.sv
// Sequential complex divider C = A*conj(B)/|B|^2 on signed Q1.(N-1) data, restoring division.
// Define CDIV_ROUND_EN to add a rounding quotient bit (round half away from zero, one extra cycle).
module cdiv_seq #(
  parameter int N = 16
) (
  input logic       clk,
  input logic       reset,
  cdiv_seq_if.slave bus
);

  localparam int PW = 2 * N;
  localparam int NW = 2 * N + 1;
  localparam int RW = 2 * N + 2;
  localparam int QM = N + 2;
`ifdef CDIV_ROUND_EN
  localparam int QS = N + 2;
`else
  localparam int QS = N + 1;
`endif
  localparam int CW = $clog2(QS);

  localparam logic [QM-1:0] LIM_P = {3'b000, {(N-1){1'b1}}};
  localparam logic [QM-1:0] LIM_N = {2'b00, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  SAT_P = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  SAT_N = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic signed [N-1:0] r_ar;
  logic signed [N-1:0] r_ai;
  logic signed [N-1:0] r_br;
  logic signed [N-1:0] r_bi;
  logic [PW-1:0]       r_d;
  logic [RW-1:0]       r_rem_r;
  logic [RW-1:0]       r_rem_i;
  logic [QS-2:0]       r_q_r;
  logic [QS-2:0]       r_q_i;
  logic                r_neg_r;
  logic                r_neg_i;
  logic                r_pre_r;
  logic                r_pre_i;
  logic                r_zero;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic                r_dz;
  logic signed [N-1:0] r_cr;
  logic signed [N-1:0] r_ci;

  logic signed [PW-1:0] w_p_rr;
  logic signed [PW-1:0] w_p_ii;
  logic signed [PW-1:0] w_p_ir;
  logic signed [PW-1:0] w_p_ri;
  logic signed [PW-1:0] w_p_bbr;
  logic signed [PW-1:0] w_p_bbi;
  logic signed [NW-1:0] w_nr;
  logic signed [NW-1:0] w_ni;
  logic [NW-1:0]        w_mag_r;
  logic [NW-1:0]        w_mag_i;
  logic [PW-1:0]        w_d;
  logic [RW-1:0]        w_d2_new;
  logic [RW-1:0]        w_d2;
  logic                 w_ge_r;
  logic                 w_ge_i;
  logic [RW-1:0]        w_sub_r;
  logic [RW-1:0]        w_sub_i;
  logic                 w_last;
  logic [QS-1:0]        w_full_r;
  logic [QS-1:0]        w_full_i;
  logic [QM-1:0]        w_qmag_r;
  logic [QM-1:0]        w_qmag_i;
  logic [N:0]           w_fin_r;
  logic [N:0]           w_fin_i;

  // Returns {saturated, signed result} from a quotient magnitude, its sign and the pre-overflow flag.
  function automatic logic [N:0] f_finish(input logic [QM-1:0] q, input logic neg, input logic pre);
    logic [N:0] res;
    if (pre || (!neg && (q > LIM_P)) || (neg && (q > LIM_N))) begin
      res = {1'b1, (neg ? SAT_N : SAT_P)};
    end else begin
      res = {1'b0, (neg ? (~q[N-1:0] + {{(N-1){1'b0}}, 1'b1}) : q[N-1:0])};
    end
    return res;
  endfunction

  assign w_p_rr  = r_ar * r_br;
  assign w_p_ii  = r_ai * r_bi;
  assign w_p_ir  = r_ai * r_br;
  assign w_p_ri  = r_ar * r_bi;
  assign w_p_bbr = r_br * r_br;
  assign w_p_bbi = r_bi * r_bi;

  assign w_nr    = NW'(w_p_rr) + NW'(w_p_ii);
  assign w_ni    = NW'(w_p_ir) - NW'(w_p_ri);
  assign w_mag_r = w_nr[NW-1] ? -w_nr : w_nr;
  assign w_mag_i = w_ni[NW-1] ? -w_ni : w_ni;
  assign w_d     = $unsigned(w_p_bbr) + $unsigned(w_p_bbi);

  // The remainder is doubled after every step, so comparing it with 2D walks the quotient bits down.
  assign w_d2_new = {1'b0, w_d, 1'b0};
  assign w_d2     = {1'b0, r_d, 1'b0};
  assign w_ge_r   = (r_rem_r >= w_d2);
  assign w_ge_i   = (r_rem_i >= w_d2);
  assign w_sub_r  = w_ge_r ? (r_rem_r - w_d2) : r_rem_r;
  assign w_sub_i  = w_ge_i ? (r_rem_i - w_d2) : r_rem_i;
  assign w_last   = (r_cnt == {CW{1'b0}});

  assign w_full_r = {r_q_r, w_ge_r};
  assign w_full_i = {r_q_i, w_ge_i};
`ifdef CDIV_ROUND_EN
  assign w_qmag_r = QM'(w_full_r[QS-1:1]) + QM'(w_full_r[0]);
  assign w_qmag_i = QM'(w_full_i[QS-1:1]) + QM'(w_full_i[0]);
`else
  assign w_qmag_r = QM'(w_full_r);
  assign w_qmag_i = QM'(w_full_i);
`endif
  assign w_fin_r  = f_finish(w_qmag_r, r_neg_r, r_pre_r);
  assign w_fin_i  = f_finish(w_qmag_i, r_neg_i, r_pre_i);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nx = S_MULT;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_MULT: begin
        w_state_nx = S_DIV;
      end
      S_DIV: begin
        if (w_last) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DIV;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Operand capture, product/magnitude setup and the shared restoring-division steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ar    <= {N{1'b0}};
      r_ai    <= {N{1'b0}};
      r_br    <= {N{1'b0}};
      r_bi    <= {N{1'b0}};
      r_d     <= {PW{1'b0}};
      r_rem_r <= {RW{1'b0}};
      r_rem_i <= {RW{1'b0}};
      r_q_r   <= {(QS-1){1'b0}};
      r_q_i   <= {(QS-1){1'b0}};
      r_neg_r <= 1'b0;
      r_neg_i <= 1'b0;
      r_pre_r <= 1'b0;
      r_pre_i <= 1'b0;
      r_zero  <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ar <= bus.Ar;
            r_ai <= bus.Ai;
            r_br <= bus.Br;
            r_bi <= bus.Bi;
          end
        end
        S_MULT: begin
          r_d     <= w_d;
          r_rem_r <= {1'b0, w_mag_r};
          r_rem_i <= {1'b0, w_mag_i};
          r_neg_r <= w_nr[NW-1];
          r_neg_i <= w_ni[NW-1];
          r_pre_r <= ({1'b0, w_mag_r} >= w_d2_new);
          r_pre_i <= ({1'b0, w_mag_i} >= w_d2_new);
          r_zero  <= (w_d == {PW{1'b0}});
          r_q_r   <= {(QS-1){1'b0}};
          r_q_i   <= {(QS-1){1'b0}};
          r_cnt   <= CW'(QS - 1);
        end
        S_DIV: begin
          r_rem_r <= w_sub_r << 1;
          r_rem_i <= w_sub_i << 1;
          r_q_r   <= {r_q_r[QS-3:0], w_ge_r};
          r_q_i   <= {r_q_i[QS-3:0], w_ge_i};
          r_cnt   <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Handshake flags and result registers; results only change on the final division step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cr   <= {N{1'b0}};
      r_ci   <= {N{1'b0}};
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != S_IDLE);
      r_done <= (r_state == S_DIV) && w_last;
      if ((r_state == S_DIV) && w_last) begin
        if (r_zero) begin
          r_cr  <= {N{1'b0}};
          r_ci  <= {N{1'b0}};
          r_ovf <= 1'b0;
          r_dz  <= 1'b1;
        end else begin
          r_cr  <= w_fin_r[N-1:0];
          r_ci  <= w_fin_i[N-1:0];
          r_ovf <= w_fin_r[N] | w_fin_i[N];
          r_dz  <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Cr   = r_cr;
  assign bus.Ci   = r_ci;
  assign bus.ovf  = r_ovf;
  assign bus.dz   = r_dz;

endmodule

// File: tb/tb_cdiv_seq.sv
// Self-checking bench for cdiv_seq: directed cases plus random operands against an arithmetic model.
module tb_cdiv_seq;
  localparam int N = 16;
`ifdef CDIV_ROUND_EN
  localparam int LAT = 19;
  localparam int THIRD = 10923;
`else
  localparam int LAT = 18;
  localparam int THIRD = 10922;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  longint exp_cr;
  longint exp_ci;
  logic   exp_ovf;
  logic   exp_dz;

  cdiv_seq_if #(.N(N)) u_if ();

  cdiv_seq #(.N(N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One part: quotient of |n|*2^15/d (rounded or truncated), sign applied, clamped to Q1.15.
  function automatic void model_part(input longint n, input longint d, output longint c, output logic sat);
    longint m;
    longint q;
    m = (n < 0) ? -n : n;
`ifdef CDIV_ROUND_EN
    q = (m * 65536 + d) / (2 * d);
`else
    q = (m * 32768) / d;
`endif
    sat = 1'b0;
    if (n < 0) begin
      if (q > 32768) begin c = -32768; sat = 1'b1; end
      else c = -q;
    end else begin
      if (q > 32767) begin c = 32767; sat = 1'b1; end
      else c = q;
    end
  endfunction

  function automatic void model(input longint ar, input longint ai, input longint br, input longint bi);
    longint nr, ni, d;
    logic sr, si;
    nr = ar * br + ai * bi;
    ni = ai * br - ar * bi;
    d  = br * br + bi * bi;
    if (d == 0) begin
      exp_cr = 0; exp_ci = 0; exp_ovf = 1'b0; exp_dz = 1'b1;
    end else begin
      model_part(nr, d, exp_cr, sr);
      model_part(ni, d, exp_ci, si);
      exp_ovf = sr | si;
      exp_dz  = 1'b0;
    end
  endfunction

  task automatic drive(input longint ar, input longint ai, input longint br, input longint bi);
    u_if.Ar = 16'(ar);
    u_if.Ai = 16'(ai);
    u_if.Br = 16'(br);
    u_if.Bi = 16'(bi);
    u_if.start = 1'b1;
    model(ar, ai, br, bi);
  endtask

  task automatic launch(input longint ar, input longint ai, input longint br, input longint bi);
    @(negedge clk);
    drive(ar, ai, br, bi);
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Called one negedge after the accept edge; returns in the done cycle. disturb pokes start/inputs while busy.
  task automatic wait_done(input string tag, input bit disturb);
    int k;
    int bcnt;
    bit got;
    k = 0;
    got = 1'b0;
    bcnt = (u_if.busy === 1'b1) ? 1 : 0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (disturb && k == 5) begin
        u_if.Ar = 16'($urandom);
        u_if.Ai = 16'($urandom);
        u_if.Br = 16'($urandom);
        u_if.Bi = 16'($urandom);
        u_if.start = 1'b1;
      end else if (disturb && k == 7) begin
        u_if.start = 1'b0;
      end
      if (u_if.done === 1'b1) got = 1'b1;
      else if (u_if.busy === 1'b1) bcnt++;
    end
    check({tag, " done seen"}, got, 1);
    check({tag, " latency"}, k, LAT);
    check({tag, " busy cycles"}, bcnt, LAT);
    check({tag, " busy at done"}, u_if.busy, 0);
    check({tag, " Cr"}, $signed(u_if.Cr), exp_cr);
    check({tag, " Ci"}, $signed(u_if.Ci), exp_ci);
    check({tag, " ovf"}, u_if.ovf, exp_ovf);
    check({tag, " dz"}, u_if.dz, exp_dz);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (u_if.done !== 1'b0) cnt++;
    end
    check({tag, " no extra done"}, cnt, 0);
  endtask

  initial begin
    longint ar, ai, br, bi;
    reset = 1'b1;
    u_if.start = 1'b0;
    u_if.Ar = '0;
    u_if.Ai = '0;
    u_if.Br = '0;
    u_if.Bi = '0;
    #1 reset = 1'b0;
    #1;
    check("reset busy", u_if.busy, 0);
    check("reset done", u_if.done, 0);
    check("reset Cr", $signed(u_if.Cr), 0);
    check("reset Ci", $signed(u_if.Ci), 0);
    check("reset ovf", u_if.ovf, 0);
    check("reset dz", u_if.dz, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    launch(8192, 0, 16384, 0);
    wait_done("real", 1'b0);
    check("real Cr const", $signed(u_if.Cr), 16384);
    count_dones("real pulse", 1);

    launch(16384, 0, 0, -32768);
    wait_done("imag", 1'b0);
    check("imag Ci const", $signed(u_if.Ci), 16384);
    check("imag Cr const", $signed(u_if.Cr), 0);

    launch(-8192, 0, 16384, 0);
    wait_done("neg", 1'b0);
    check("neg Cr const", $signed(u_if.Cr), -16384);

    launch(16384, 0, 8192, 0);
    wait_done("sat pos", 1'b0);
    check("sat pos Cr const", $signed(u_if.Cr), 32767);
    check("sat pos ovf const", u_if.ovf, 1);

    launch(-16384, 0, 8192, 0);
    wait_done("sat neg", 1'b0);
    check("sat neg Cr const", $signed(u_if.Cr), -32768);

    launch(100, -5, 0, 0);
    wait_done("dz", 1'b0);
    check("dz flag const", u_if.dz, 1);

    launch(1, 0, 3, 0);
    wait_done("third", 1'b0);
    check("third Cr const", $signed(u_if.Cr), THIRD);

    launch(3000, -2000, 12000, 7000);
    wait_done("busy start", 1'b1);
    count_dones("busy start", 30);

    launch(5000, 1000, -20000, 9000);
    wait_done("back1", 1'b0);
    drive(-7000, 4000, 3000, -25000);
    @(negedge clk);
    u_if.start = 1'b0;
    wait_done("back2", 1'b0);
    count_dones("back2 pulse", 1);

    launch(8192, 0, 16384, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("abort busy", u_if.busy, 0);
    check("abort done", u_if.done, 0);
    check("abort Cr", $signed(u_if.Cr), 0);
    check("abort Ci", $signed(u_if.Ci), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_dones("abort", 30);
    check("abort Cr held", $signed(u_if.Cr), 0);

    launch(-3000, 12000, 20000, -5000);
    wait_done("after reset", 1'b0);

    for (int i = 0; i < 40; i++) begin
      ar = longint'($urandom_range(0, 65535)) - 32768;
      ai = longint'($urandom_range(0, 65535)) - 32768;
      br = longint'($urandom_range(0, 65535)) - 32768;
      bi = longint'($urandom_range(0, 65535)) - 32768;
      ar = ar / (longint'(1) << (i % 6));
      ai = ai / (longint'(1) << (i % 6));
      if (i % 7 == 3) bi = 0;
      if (i % 9 == 5) begin ar = -32768; br = -32768; bi = 0; end
      if (i % 13 == 7) begin br = 0; bi = 0; end
      launch(ar, ai, br, bi);
      wait_done($sformatf("rnd%0d", i), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
